// File: rtl/multicycle_controller_pkg.sv
// controller_pkg
// Shared encodings for the multi-cycle RV32I controller: FSM state enum,
// ALU operation codes, immediate-extender formats, datapath mux selects
// and the RV32I opcodes the controller understands.
package controller_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    JALR_A   = 4'd10,
    JALR_B   = 4'd11,
    BRANCH   = 4'd12,
    LUI      = 4'd13,
    ILLEGAL  = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_RSVD = 3'b111
  } aluop_t;

  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_S = 3'b001,
    EXT_B = 3'b010,
    EXT_J = 3'b011,
    EXT_U = 3'b100
  } extend_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } srca_t;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_t;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_MEMDATA = 2'b01,
    RES_ALU     = 2'b10
  } result_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
// Bundle of signals between the multi-cycle controller and the datapath.
//   Datapath -> controller: op, func3, func7 (from IR), zero, neg (ALU flags)
//   Controller -> datapath: write enables, mux selects, aluop, extend_func,
//                           illegal flag and debug state
// Modports: master = controller, slave = datapath.
interface multicycle_controller_if;

  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       neg;

  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [2:0] aluop;
  logic [2:0] extend_func;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, func3, func7, zero, neg,
    output pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, aluop, extend_func, illegal, state
  );

  modport slave (
    output op, func3, func7, zero, neg,
    input  pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, aluop, extend_func, illegal, state
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder
// Combinational decode of op/func3/func7 into the ALU operation for R-type
// and I-ALU instructions, plus a legal flag saying whether the func fields
// name an operation the datapath supports.
//   i_op     : instruction[6:0]
//   i_func3  : instruction[14:12]
//   i_func7  : instruction[31:25]
//   o_aluop  : ALU operation code
//   o_legal  : 1 when the func fields are supported (always 1 for non-ALU ops)
module alu_decoder
  import controller_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_func3,
  input  logic [6:0] i_func7,
  output aluop_t     o_aluop,
  output logic       o_legal
);

  logic w_f7Zero;
  logic w_f7Sub;

  assign w_f7Zero = (i_func7 == 7'b0000000);
  assign w_f7Sub  = (i_func7 == 7'b0100000);

  // R-type requires an exact func7 (only add/sub differ); I-ALU func7 bits
  // are immediate bits and are ignored. Shifts are not supported.
  always_comb begin
    o_aluop = ALU_ADD;
    o_legal = 1'b1;
    if (i_op == OP_RTYPE) begin
      o_legal = 1'b0;
      case (i_func3)
        3'b000: begin
          o_aluop = w_f7Sub ? ALU_SUB : ALU_ADD;
          o_legal = w_f7Zero | w_f7Sub;
        end
        3'b010: begin o_aluop = ALU_SLT;  o_legal = w_f7Zero; end
        3'b011: begin o_aluop = ALU_SLTU; o_legal = w_f7Zero; end
        3'b100: begin o_aluop = ALU_XOR;  o_legal = w_f7Zero; end
        3'b110: begin o_aluop = ALU_OR;   o_legal = w_f7Zero; end
        3'b111: begin o_aluop = ALU_AND;  o_legal = w_f7Zero; end
        default: o_legal = 1'b0;
      endcase
    end else if (i_op == OP_IALU) begin
      o_legal = 1'b1;
      case (i_func3)
        3'b000: o_aluop = ALU_ADD;
        3'b010: o_aluop = ALU_SLT;
        3'b011: o_aluop = ALU_SLTU;
        3'b100: o_aluop = ALU_XOR;
        3'b110: o_aluop = ALU_OR;
        3'b111: o_aluop = ALU_AND;
        default: o_legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore-style FSM sequencing the multi-cycle RV32I datapath. Each state
// drives the mux selects and write enables for one datapath step; an
// instruction takes 3 (branch), 4 (R/I-ALU, sw, lui, jal) or 5 (lw, jalr)
// cycles. Unsupported instructions park the FSM in ILLEGAL until reset.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : controller side (master) of multicycle_controller_if
module multicycle_controller
  import controller_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  multicycle_controller_if.master       bus
);

  state_t  r_state;
  state_t  w_stateNext;

  aluop_t  w_decAluop;
  logic    w_decLegal;

  logic    w_pcwrite;
  logic    w_adrsrc;
  logic    w_memwrite;
  logic    w_irwrite;
  logic    w_regwrite;
  result_t w_resultsrc;
  srca_t   w_alusrca;
  srcb_t   w_alusrcb;
  aluop_t  w_aluop;
  extend_t w_extend;
  logic    w_illegal;
  logic    w_taken;

  alu_decoder u_aluDecoder (
    .i_op    (bus.op),
    .i_func3 (bus.func3),
    .i_func7 (bus.func7),
    .o_aluop (w_decAluop),
    .o_legal (w_decLegal)
  );

  // Branch condition from func3 and the ALU flags of rs1 - rs2.
  always_comb begin
    case (bus.func3)
      3'b000:  w_taken = bus.zero;
      3'b001:  w_taken = ~bus.zero;
      3'b100:  w_taken = bus.neg;
      3'b101:  w_taken = ~bus.neg;
      default: w_taken = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and per-state outputs.
  always_comb begin
    w_stateNext = FETCH;
    w_pcwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_resultsrc = RES_ALUOUT;
    w_alusrca   = SRCA_PC;
    w_alusrcb   = SRCB_RD2;
    w_aluop     = ALU_ADD;
    w_extend    = EXT_I;
    w_illegal   = 1'b0;
    case (r_state)
      FETCH: begin
        w_irwrite   = 1'b1;
        w_pcwrite   = 1'b1;
        w_alusrcb   = SRCB_FOUR;
        w_resultsrc = RES_ALU;
        w_stateNext = DECODE;
      end
      DECODE: begin
        // ALUOut <= oldPC + imm, the branch or jal target.
        w_alusrca = SRCA_OLDPC;
        w_alusrcb = SRCB_IMM;
        w_extend  = (bus.op == OP_JAL) ? EXT_J : EXT_B;
        case (bus.op)
          OP_LOAD, OP_STORE: w_stateNext = MEMADR;
          OP_RTYPE:          w_stateNext = w_decLegal ? EXECR : ILLEGAL;
          OP_IALU:           w_stateNext = w_decLegal ? EXECI : ILLEGAL;
          OP_JAL:            w_stateNext = JAL;
          OP_JALR:           w_stateNext = JALR_A;
          OP_BRANCH:         w_stateNext = BRANCH;
          OP_LUI:            w_stateNext = LUI;
          default:           w_stateNext = ILLEGAL;
        endcase
      end
      MEMADR: begin
        w_alusrca   = SRCA_RD1;
        w_alusrcb   = SRCB_IMM;
        w_extend    = (bus.op == OP_STORE) ? EXT_S : EXT_I;
        w_stateNext = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        w_adrsrc    = 1'b1;
        w_stateNext = MEMWB;
      end
      MEMWB: begin
        w_resultsrc = RES_MEMDATA;
        w_regwrite  = 1'b1;
        w_stateNext = FETCH;
      end
      MEMWRITE: begin
        w_adrsrc    = 1'b1;
        w_memwrite  = 1'b1;
        w_stateNext = FETCH;
      end
      EXECR: begin
        w_alusrca   = SRCA_RD1;
        w_aluop     = w_decAluop;
        w_stateNext = ALUWB;
      end
      EXECI: begin
        w_alusrca   = SRCA_RD1;
        w_alusrcb   = SRCB_IMM;
        w_aluop     = w_decAluop;
        w_stateNext = ALUWB;
      end
      ALUWB: begin
        w_regwrite  = 1'b1;
        w_stateNext = FETCH;
      end
      JAL, JALR_B: begin
        // PC <= ALUOut (target) while the ALU forms oldPC + 4 for rd.
        w_alusrca   = SRCA_OLDPC;
        w_alusrcb   = SRCB_FOUR;
        w_pcwrite   = 1'b1;
        w_stateNext = ALUWB;
      end
      JALR_A: begin
        w_alusrca   = SRCA_RD1;
        w_alusrcb   = SRCB_IMM;
        w_stateNext = JALR_B;
      end
      BRANCH: begin
        w_alusrca   = SRCA_RD1;
        w_aluop     = ALU_SUB;
        w_pcwrite   = w_taken;
        w_stateNext = FETCH;
      end
      LUI: begin
        w_alusrca   = SRCA_ZERO;
        w_alusrcb   = SRCB_IMM;
        w_extend    = EXT_U;
        w_stateNext = ALUWB;
      end
      ILLEGAL: begin
        w_illegal   = 1'b1;
        w_stateNext = ILLEGAL;
      end
      default: w_stateNext = FETCH;
    endcase
  end

  // Enables are gated by reset so an abandoned instruction never writes.
  assign bus.pcwrite     = w_pcwrite  & rst;
  assign bus.irwrite     = w_irwrite  & rst;
  assign bus.regwrite    = w_regwrite & rst;
  assign bus.memwrite    = w_memwrite & rst;
  assign bus.adrsrc      = w_adrsrc;
  assign bus.resultsrc   = w_resultsrc;
  assign bus.alusrca     = w_alusrca;
  assign bus.alusrcb     = w_alusrcb;
  assign bus.aluop       = w_aluop;
  assign bus.extend_func = w_extend;
  assign bus.illegal     = w_illegal;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed bench for multicycle_controller: each task drives one instruction
// class and compares the full control-output vector in every cycle against
// hand-written per-state constants.
module tb_multicycle_controller;
  import controller_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       rgw;
    logic       mmw;
    logic       adr;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] aop;
    logic [2:0] ext;
    logic       ill;
  } snap_t;

  localparam snap_t S_RESET    = '{st: FETCH,    pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b10, sa: 2'b00, sb: 2'b10, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_FETCH    = '{st: FETCH,    pcw: 1'b1, irw: 1'b1, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b10, sa: 2'b00, sb: 2'b10, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_DECODE_B = '{st: DECODE,   pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b01, sb: 2'b01, aop: 3'b000, ext: 3'b010, ill: 1'b0};
  localparam snap_t S_DECODE_J = '{st: DECODE,   pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b01, sb: 2'b01, aop: 3'b000, ext: 3'b011, ill: 1'b0};
  localparam snap_t S_MEMADR_L = '{st: MEMADR,   pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b10, sb: 2'b01, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_MEMADR_S = '{st: MEMADR,   pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b10, sb: 2'b01, aop: 3'b000, ext: 3'b001, ill: 1'b0};
  localparam snap_t S_MEMREAD  = '{st: MEMREAD,  pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b1, res: 2'b00, sa: 2'b00, sb: 2'b00, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_MEMWB    = '{st: MEMWB,    pcw: 1'b0, irw: 1'b0, rgw: 1'b1, mmw: 1'b0, adr: 1'b0, res: 2'b01, sa: 2'b00, sb: 2'b00, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_MEMWRITE = '{st: MEMWRITE, pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b1, adr: 1'b1, res: 2'b00, sa: 2'b00, sb: 2'b00, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_EXECR    = '{st: EXECR,    pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b10, sb: 2'b00, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_EXECI    = '{st: EXECI,    pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b10, sb: 2'b01, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_ALUWB    = '{st: ALUWB,    pcw: 1'b0, irw: 1'b0, rgw: 1'b1, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b00, sb: 2'b00, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_JAL      = '{st: JAL,      pcw: 1'b1, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b01, sb: 2'b10, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_JALR_A   = '{st: JALR_A,   pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b10, sb: 2'b01, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_JALR_B   = '{st: JALR_B,   pcw: 1'b1, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b01, sb: 2'b10, aop: 3'b000, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_BRANCH   = '{st: BRANCH,   pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b10, sb: 2'b00, aop: 3'b001, ext: 3'b000, ill: 1'b0};
  localparam snap_t S_LUI      = '{st: LUI,      pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b11, sb: 2'b01, aop: 3'b000, ext: 3'b100, ill: 1'b0};
  localparam snap_t S_ILLEGAL  = '{st: ILLEGAL,  pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mmw: 1'b0, adr: 1'b0, res: 2'b00, sa: 2'b00, sb: 2'b00, aop: 3'b000, ext: 3'b000, ill: 1'b1};

  logic clk = 1'b0;
  logic rst;
  int   testsRun = 0;
  int   testsFailed = 0;
  snap_t tr [16];
  int   trLen;

  always #5 clk = ~clk;

  multicycle_controller_if intf();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  function automatic snap_t takeSnap();
    snap_t s;
    s.st  = intf.state;
    s.pcw = intf.pcwrite;
    s.irw = intf.irwrite;
    s.rgw = intf.regwrite;
    s.mmw = intf.memwrite;
    s.adr = intf.adrsrc;
    s.res = intf.resultsrc;
    s.sa  = intf.alusrca;
    s.sb  = intf.alusrcb;
    s.aop = intf.aluop;
    s.ext = intf.extend_func;
    s.ill = intf.illegal;
    return s;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setInstr(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic z, input logic n);
    intf.op    = op;
    intf.func3 = f3;
    intf.func7 = f7;
    intf.zero  = z;
    intf.neg   = n;
  endtask

  // Records one snapshot per cycle from FETCH until FETCH comes round again
  // (bounded at 16 cycles so a stuck FSM still returns).
  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic z, input logic n);
    setInstr(op, f3, f7, z, n);
    trLen = 0;
    do begin
      tr[trLen] = takeSnap();
      trLen++;
      stepCycle();
    end while (intf.state != FETCH && trLen < 16);
  endtask

  task automatic test_reset();
    snap_t s;
    rst = 1'b0;
    setInstr(OP_RTYPE, 3'b000, 7'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s = takeSnap();
      testsRun++;
      if (s !== S_RESET) begin
        testsFailed++;
        $display("[TB] FAIL reset_hold[%0d]: got %h expected %h", i, s, S_RESET);
      end
    end
    rst = 1'b1;
    #1;
    s = takeSnap();
    testsRun++;
    if (s !== S_FETCH) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_fetch: got %h expected %h", s, S_FETCH);
    end
    stepCycle();
    s = takeSnap();
    testsRun++;
    if (s !== S_DECODE_B) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_decode: got %h expected %h", s, S_DECODE_B);
    end
    stepCycle();
    stepCycle();
    stepCycle();
    s = takeSnap();
    testsRun++;
    if (s !== S_FETCH) begin
      testsFailed++;
      $display("[TB] FAIL reset_first_add_done: got %h expected %h", s, S_FETCH);
    end
  endtask

  task automatic test_alu();
    typedef struct packed {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       isR;
      logic [2:0] aop;
    } aluvec_t;
    aluvec_t v [11];
    snap_t   e;
    v[0]  = '{OP_RTYPE, 3'b000, 7'h00, 1'b1, 3'b000};
    v[1]  = '{OP_RTYPE, 3'b000, 7'h20, 1'b1, 3'b001};
    v[2]  = '{OP_RTYPE, 3'b111, 7'h00, 1'b1, 3'b010};
    v[3]  = '{OP_RTYPE, 3'b110, 7'h00, 1'b1, 3'b011};
    v[4]  = '{OP_RTYPE, 3'b010, 7'h00, 1'b1, 3'b100};
    v[5]  = '{OP_RTYPE, 3'b100, 7'h00, 1'b1, 3'b101};
    v[6]  = '{OP_RTYPE, 3'b011, 7'h00, 1'b1, 3'b110};
    v[7]  = '{OP_IALU,  3'b000, 7'h55, 1'b0, 3'b000};
    v[8]  = '{OP_IALU,  3'b100, 7'h7f, 1'b0, 3'b101};
    v[9]  = '{OP_IALU,  3'b011, 7'h20, 1'b0, 3'b110};
    v[10] = '{OP_IALU,  3'b111, 7'h00, 1'b0, 3'b010};
    for (int i = 0; i < 11; i++) begin
      runInstr(v[i].op, v[i].f3, v[i].f7, 1'b1, 1'b1);
      e = v[i].isR ? S_EXECR : S_EXECI;
      e.aop = v[i].aop;
      testsRun++;
      if (trLen !== 4 || tr[0] !== S_FETCH || tr[1] !== S_DECODE_B ||
          tr[2] !== e || tr[3] !== S_ALUWB) begin
        testsFailed++;
        $display("[TB] FAIL alu_vec[%0d]: got len %0d %h %h %h %h expected len 4 %h %h %h %h",
                 i, trLen, tr[0], tr[1], tr[2], tr[3], S_FETCH, S_DECODE_B, e, S_ALUWB);
      end
    end
  endtask

  task automatic test_load_store();
    runInstr(OP_LOAD, 3'b010, 7'h00, 1'b0, 1'b0);
    testsRun++;
    if (trLen !== 5 || tr[0] !== S_FETCH || tr[1] !== S_DECODE_B || tr[2] !== S_MEMADR_L ||
        tr[3] !== S_MEMREAD || tr[4] !== S_MEMWB) begin
      testsFailed++;
      $display("[TB] FAIL lw: got len %0d %h %h %h %h %h expected len 5 %h %h %h %h %h",
               trLen, tr[0], tr[1], tr[2], tr[3], tr[4],
               S_FETCH, S_DECODE_B, S_MEMADR_L, S_MEMREAD, S_MEMWB);
    end
    runInstr(OP_STORE, 3'b010, 7'h00, 1'b0, 1'b0);
    testsRun++;
    if (trLen !== 4 || tr[0] !== S_FETCH || tr[1] !== S_DECODE_B || tr[2] !== S_MEMADR_S ||
        tr[3] !== S_MEMWRITE) begin
      testsFailed++;
      $display("[TB] FAIL sw: got len %0d %h %h %h %h expected len 4 %h %h %h %h",
               trLen, tr[0], tr[1], tr[2], tr[3], S_FETCH, S_DECODE_B, S_MEMADR_S, S_MEMWRITE);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3 [7];
    logic       z  [7];
    logic       n  [7];
    logic       tk [7];
    snap_t      e;
    // beq z1, beq z0, blt n1, bne z0, bge n1, bge n0, func3=010 (unsupported)
    f3[0] = 3'b000; z[0] = 1'b1; n[0] = 1'b0; tk[0] = 1'b1;
    f3[1] = 3'b000; z[1] = 1'b0; n[1] = 1'b1; tk[1] = 1'b0;
    f3[2] = 3'b100; z[2] = 1'b0; n[2] = 1'b1; tk[2] = 1'b1;
    f3[3] = 3'b001; z[3] = 1'b0; n[3] = 1'b0; tk[3] = 1'b1;
    f3[4] = 3'b101; z[4] = 1'b0; n[4] = 1'b1; tk[4] = 1'b0;
    f3[5] = 3'b101; z[5] = 1'b1; n[5] = 1'b0; tk[5] = 1'b1;
    f3[6] = 3'b010; z[6] = 1'b1; n[6] = 1'b1; tk[6] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      runInstr(OP_BRANCH, f3[i], 7'h00, z[i], n[i]);
      e = S_BRANCH;
      e.pcw = tk[i];
      testsRun++;
      if (trLen !== 3 || tr[0] !== S_FETCH || tr[1] !== S_DECODE_B || tr[2] !== e) begin
        testsFailed++;
        $display("[TB] FAIL branch[%0d]: got len %0d %h %h %h expected len 3 %h %h %h",
                 i, trLen, tr[0], tr[1], tr[2], S_FETCH, S_DECODE_B, e);
      end
    end
  endtask

  task automatic test_jumps();
    runInstr(OP_JALR, 3'b000, 7'h00, 1'b0, 1'b0);
    testsRun++;
    if (trLen !== 5 || tr[0] !== S_FETCH || tr[1] !== S_DECODE_B || tr[2] !== S_JALR_A ||
        tr[3] !== S_JALR_B || tr[4] !== S_ALUWB) begin
      testsFailed++;
      $display("[TB] FAIL jalr: got len %0d %h %h %h %h %h expected len 5 %h %h %h %h %h",
               trLen, tr[0], tr[1], tr[2], tr[3], tr[4],
               S_FETCH, S_DECODE_B, S_JALR_A, S_JALR_B, S_ALUWB);
    end
    runInstr(OP_JAL, 3'b101, 7'h3c, 1'b0, 1'b0);
    testsRun++;
    if (trLen !== 4 || tr[0] !== S_FETCH || tr[1] !== S_DECODE_J || tr[2] !== S_JAL ||
        tr[3] !== S_ALUWB) begin
      testsFailed++;
      $display("[TB] FAIL jal: got len %0d %h %h %h %h expected len 4 %h %h %h %h",
               trLen, tr[0], tr[1], tr[2], tr[3], S_FETCH, S_DECODE_J, S_JAL, S_ALUWB);
    end
    runInstr(OP_LUI, 3'b011, 7'h12, 1'b0, 1'b0);
    testsRun++;
    if (trLen !== 4 || tr[0] !== S_FETCH || tr[1] !== S_DECODE_B || tr[2] !== S_LUI ||
        tr[3] !== S_ALUWB) begin
      testsFailed++;
      $display("[TB] FAIL lui: got len %0d %h %h %h %h expected len 4 %h %h %h %h",
               trLen, tr[0], tr[1], tr[2], tr[3], S_FETCH, S_DECODE_B, S_LUI, S_ALUWB);
    end
  endtask

  task automatic test_illegal();
    logic [6:0] op [3];
    logic [2:0] f3 [3];
    logic [6:0] f7 [3];
    snap_t      s;
    // unknown opcode, R-type shift (sll), R-type with func7=0000001 (mul)
    op[0] = 7'b1111111; f3[0] = 3'b000; f7[0] = 7'h00;
    op[1] = OP_RTYPE;   f3[1] = 3'b001; f7[1] = 7'h00;
    op[2] = OP_RTYPE;   f3[2] = 3'b000; f7[2] = 7'h01;
    for (int i = 0; i < 3; i++) begin
      runInstr(op[i], f3[i], f7[i], 1'b0, 1'b0);
      testsRun++;
      if (trLen !== 16 || tr[1] !== S_DECODE_B) begin
        testsFailed++;
        $display("[TB] FAIL illegal_entry[%0d]: got len %0d %h expected len 16 %h",
                 i, trLen, tr[1], S_DECODE_B);
      end
      for (int c = 2; c < 16; c++) begin
        testsRun++;
        if (tr[c] !== S_ILLEGAL) begin
          testsFailed++;
          $display("[TB] FAIL illegal_hold[%0d] cycle %0d: got %h expected %h",
                   i, c, tr[c], S_ILLEGAL);
        end
      end
      rst = 1'b0;
      #1;
      s = takeSnap();
      testsRun++;
      if (s !== S_RESET) begin
        testsFailed++;
        $display("[TB] FAIL illegal_clear[%0d]: got %h expected %h", i, s, S_RESET);
      end
      @(negedge clk);
      rst = 1'b1;
    end
    runInstr(OP_STORE, 3'b010, 7'h00, 1'b0, 1'b0);
    testsRun++;
    if (trLen !== 4 || tr[3] !== S_MEMWRITE) begin
      testsFailed++;
      $display("[TB] FAIL illegal_recover: got len %0d %h expected len 4 %h",
               trLen, tr[3], S_MEMWRITE);
    end
  endtask

  task automatic test_reset_midway();
    snap_t s;
    setInstr(OP_LOAD, 3'b010, 7'h00, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    s = takeSnap();
    testsRun++;
    if (s !== S_MEMREAD) begin
      testsFailed++;
      $display("[TB] FAIL midway_memread: got %h expected %h", s, S_MEMREAD);
    end
    #1;
    rst = 1'b0;
    #1;
    s = takeSnap();
    testsRun++;
    if (s !== S_RESET) begin
      testsFailed++;
      $display("[TB] FAIL midway_abandon: got %h expected %h", s, S_RESET);
    end
    stepCycle();
    s = takeSnap();
    testsRun++;
    if (s !== S_RESET) begin
      testsFailed++;
      $display("[TB] FAIL midway_no_writeback: got %h expected %h", s, S_RESET);
    end
    rst = 1'b1;
    #1;
    s = takeSnap();
    testsRun++;
    if (s !== S_FETCH) begin
      testsFailed++;
      $display("[TB] FAIL midway_refetch: got %h expected %h", s, S_FETCH);
    end
    runInstr(OP_LOAD, 3'b010, 7'h00, 1'b0, 1'b0);
    testsRun++;
    if (trLen !== 5 || tr[4] !== S_MEMWB) begin
      testsFailed++;
      $display("[TB] FAIL midway_rerun: got len %0d %h expected len 5 %h", trLen, tr[4], S_MEMWB);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jumps();
    test_illegal();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences the team's multi-cycle RV32I datapath: one shared memory, instruction register, ALUOut/data registers, and the existing ALU, immediate extender and register file. Each cycle it decodes `op`, `func3` and `func7` from the instruction register, together with the ALU `zero`/`neg` flags. From these it drives every mux select and write enable. One instruction completes in 3–5 cycles. It sits beside the datapath at core top level and replaces the combinational single-cycle control unit.

## Interface
Parameters:
- none; all encodings come from `controller_pkg`.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `op` in 7: instruction[6:0] from IR.
- `func3` in 3: instruction[14:12].
- `func7` in 7: instruction[31:25].
- `zero` in 1: ALU result == 0.
- `neg` in 1: ALU result[31].
- `pcwrite` out 1: load PC from result bus.
- `adrsrc` out 1: memory address select; 0 = PC, 1 = result bus.
- `memwrite` out 1: data memory write enable.
- `irwrite` out 1: IR and oldPC load.
- `regwrite` out 1: register file write enable.
- `resultsrc` out 2: result bus select; 00 = ALUOut, 01 = memory data register, 10 = ALU result direct.
- `alusrca` out 2: ALU A select; 00 = PC, 01 = oldPC, 10 = RD1 register, 11 = zero.
- `alusrcb` out 2: ALU B select; 00 = RD2 register, 01 = immediate, 10 = constant 4.
- `aluop` out 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR, 110 SLTU, 111 reserved.
- `extend_func` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `illegal` out 1: sticky flag, unsupported instruction decoded.
- `state` out 4: current state, for debug.

## Operation
- Moore outputs decoded from `state`. The only exceptions are `pcwrite` in BRANCH and the opcode-dependent `extend_func` in DECODE.
- Outputs not listed for a state are 0. Default `aluop` = ADD.
- FETCH: `adrsrc`=0, `irwrite`=1, `alusrca`=00, `alusrcb`=10, `resultsrc`=10, `pcwrite`=1. Next state: DECODE.
- DECODE: `alusrca`=01, `alusrcb`=01. `extend_func` = J if op = jal, else B. Computes the branch/jal target into ALUOut. Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXECR
  - I-ALU → EXECI
  - jal → JAL
  - jalr → JALR_A
  - branch → BRANCH
  - lui → LUI
  - any other → ILLEGAL
- MEMADR: `alusrca`=10, `alusrcb`=01, `extend_func` = I (lw) or S (sw). Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: `adrsrc`=1, `resultsrc`=00. Next: MEMWB.
- MEMWB: `resultsrc`=01, `regwrite`=1. Next: FETCH.
- MEMWRITE: `adrsrc`=1, `resultsrc`=00, `memwrite`=1. Next: FETCH.
- EXECR: `alusrca`=10, `alusrcb`=00, `aluop` from ALU decode. Next: ALUWB.
- EXECI: `alusrca`=10, `alusrcb`=01, `extend_func`=I, `aluop` from ALU decode. Next: ALUWB.
- ALUWB: `resultsrc`=00, `regwrite`=1. Next: FETCH.
- JAL: `alusrca`=01, `alusrcb`=10, `resultsrc`=00, `pcwrite`=1. Next: ALUWB, which writes oldPC+4 to rd.
- JALR_A: `alusrca`=10, `alusrcb`=01, `extend_func`=I. Next: JALR_B.
- JALR_B: `alusrca`=01, `alusrcb`=10, `resultsrc`=00, `pcwrite`=1. Next: ALUWB.
- BRANCH: `alusrca`=10, `alusrcb`=00, `aluop`=SUB, `resultsrc`=00. `pcwrite` = taken. Next: FETCH.
  - beq: `zero`.
  - bne: `!zero`.
  - blt: `neg`.
  - bge: `!neg`.
  - other func3: not taken.
- LUI: `alusrca`=11, `alusrcb`=01, `extend_func`=U. Next: ALUWB.
- ALU decode rules:
  - R-type: add/sub (func7[5] selects SUB), and, or, xor, slt, sltu.
  - I-ALU: addi, andi, ori, xori, slti, sltiu.
  - Any unsupported func3/func7 pair goes to ILLEGAL from DECODE.
- ILLEGAL: all enables 0, `illegal`=1. Held until reset.

## Timing
- Cycles per instruction:
  - 3: branch.
  - 4: R-type, I-ALU, sw, lui, jal.
  - 5: lw, jalr.
- Exactly one `pcwrite` pulse per instruction in FETCH. A second pulse occurs only in JAL, JALR_B, or a taken BRANCH.
- Exactly one `regwrite` or `memwrite` pulse per instruction; none for branch.
- Reset (`rst`=0):
  - `state` = FETCH, `illegal`=0.
  - `pcwrite`, `irwrite`, `regwrite`, `memwrite` forced 0 combinationally.
  - Mux outputs hold their FETCH values.
- Release of reset: the first rising edge with `rst`=1 performs FETCH.
- Reset asserted mid-instruction: the instruction is abandoned immediately, with no further write pulses.
- `zero`/`neg` are sampled only in BRANCH, same cycle. In all other states they are don't-care.

## Structure
- `controller_pkg` holds:
  - state enum (4-bit);
  - `aluop`, `extend_func`, `alusrca`, `alusrcb`, `resultsrc` encodings;
  - opcode constants: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111.
- One sub-module, `alu_decoder`: combinational op/func3/func7 → `aluop` plus a `legal` flag.

## Test plan
- Reset held low 3 cycles, then released → all enables 0 during reset. Cycle 1 after release: `pcwrite`=1, `irwrite`=1; `state`=DECODE next cycle.
- `add x3,x1,x2` (op 0110011, func3 000, func7 0) → FETCH, DECODE, EXECR with `aluop`=000, ALUWB with `regwrite`=1; 4 cycles.
- `lw` then `sw` (op 0000011, 0100011) → lw takes 5 cycles, `regwrite` in MEMWB with `resultsrc`=01. sw takes 4 cycles, `memwrite`=1 with `adrsrc`=1.
- beq with `zero`=1, then with `zero`=0; blt with `neg`=1 → `pcwrite`=1, 0, 1 respectively in BRANCH; 3 cycles each.
- `jalr` (op 1100111) → JALR_A, JALR_B with `pcwrite`=1, then ALUWB with `regwrite`=1; 5 cycles.
- op 1111111 → ILLEGAL, `illegal`=1, no enables for 10 cycles. `rst` low clears it to FETCH.
